// File: rtl/irq_stim_gen.sv
// irq_stim_gen: core reset sequencer plus NUM_IRQ programmable periodic interrupts.
// Define IRQ_STIM_MISS_CNT_EN to add per-channel missed-interrupt counters (miss_cnt_o).
`timescale 1ns/1ps
module irq_stim_gen #(
    parameter int NUM_IRQ    = 3,
    parameter int RST_CYCLES = 10,
    parameter int RUN_CYCLES = 10000,
    parameter int CNT_W      = 32,
    localparam int CH_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cfg_we_i,
    input  logic [CH_W-1:0]    cfg_ch_i,
    input  logic [CNT_W-1:0]   cfg_period_i,
    input  logic               cfg_level_i,
    input  logic [NUM_IRQ-1:0] irq_ack_i,
    output logic               core_rstn_o,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic               run_o,
    output logic               done_o,
`ifdef IRQ_STIM_MISS_CNT_EN
    output logic [8*NUM_IRQ-1:0] miss_cnt_o,
    output logic [CNT_W-1:0]     cycle_cnt_o
`else
    output logic [CNT_W-1:0]     cycle_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_END  = CNT_W'(RUN_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               core_rstn_q, core_rstn_d;
    logic               run_q, run_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   period_q [NUM_IRQ];
    logic [CNT_W-1:0]   period_d [NUM_IRQ];
    logic [CNT_W-1:0]   ch_cnt_q [NUM_IRQ];
    logic [CNT_W-1:0]   ch_cnt_d [NUM_IRQ];
    logic [NUM_IRQ-1:0] level_q, level_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] wr_sel;
    logic [NUM_IRQ-1:0] fire;
    logic               enter_run;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cyc_d      = cyc_q;
        unique case (state_q)
            S_HOLD: begin
                if ((RST_CYCLES == 0) || (hold_cnt_q == RST_LAST)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + ONE;
                end
            end
            S_RUN: begin
                if ((RUN_CYCLES != 0) && (cyc_q == RUN_LAST)) begin
                    state_d = S_DONE;
                    cyc_d   = RUN_END;
                end else begin
                    cyc_d = cyc_q + ONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
        enter_run   = (state_q == S_HOLD) && (state_d == S_RUN);
        core_rstn_d = (state_d != S_HOLD);
        run_d       = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    // Channels out of range of NUM_IRQ never match, so their writes vanish.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            wr_sel[i] = cfg_we_i && (cfg_ch_i == CH_W'(i));
            fire[i]   = (state_q == S_RUN) && (period_q[i] != '0)
                        && (ch_cnt_q[i] == '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            period_d[i] = period_q[i];
            level_d[i]  = level_q[i];
            ch_cnt_d[i] = ch_cnt_q[i];
            pend_d[i]   = pend_q[i];
            irq_d[i]    = 1'b0;
            if (wr_sel[i]) begin
                period_d[i] = cfg_period_i;
                level_d[i]  = cfg_level_i;
                ch_cnt_d[i] = cfg_period_i - ONE;
                pend_d[i]   = 1'b0;
            end else if (enter_run) begin
                ch_cnt_d[i] = period_q[i] - ONE;
            end else if (state_q == S_RUN) begin
                if (period_q[i] == '0) begin
                    pend_d[i] = 1'b0;
                end else begin
                    ch_cnt_d[i] = fire[i] ? (period_q[i] - ONE)
                                          : (ch_cnt_q[i] - ONE);
                    if (level_q[i]) begin
                        pend_d[i] = fire[i] | (pend_q[i] & ~irq_ack_i[i]);
                    end
                    irq_d[i] = level_q[i] ? pend_d[i] : fire[i];
                end
            end
            // A fire on the last RUN cycle must not leak into DONE.
            if (state_d != S_RUN) begin
                pend_d[i] = 1'b0;
                irq_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            cyc_q       <= '0;
            core_rstn_q <= 1'b0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            period_q    <= '{default: '0};
            ch_cnt_q    <= '{default: '0};
            level_q     <= '0;
            pend_q      <= '0;
            irq_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cyc_q       <= cyc_d;
            core_rstn_q <= core_rstn_d;
            run_q       <= run_d;
            done_q      <= done_d;
            period_q    <= period_d;
            ch_cnt_q    <= ch_cnt_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            irq_q       <= irq_d;
        end
    end

    assign core_rstn_o = core_rstn_q;
    assign run_o       = run_q;
    assign done_o      = done_q;
    assign irq_o       = irq_q;
    assign cycle_cnt_o = cyc_q;

`ifdef IRQ_STIM_MISS_CNT_EN
    logic [7:0] miss_q [NUM_IRQ];
    logic [7:0] miss_d [NUM_IRQ];

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            miss_d[i] = miss_q[i];
            if (wr_sel[i]) begin
                miss_d[i] = '0;
            end else if (fire[i] && level_q[i] && pend_q[i]
                         && !irq_ack_i[i] && (miss_q[i] != 8'hff)) begin
                miss_d[i] = miss_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            miss_q <= '{default: '0};
        end else begin
            miss_q <= miss_d;
        end
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_miss
        assign miss_cnt_o[8*g +: 8] = miss_q[g];
    end
`endif

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed bench for irq_stim_gen: sequencing, pulse/level channels, reset.
// A second instance with RUN_CYCLES=0 shares all inputs.
`timescale 1ns/1ps
module tb_irq_stim_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_period;
    logic        cfg_level;
    logic [2:0]  ack;

    logic        core_rstn, run, done;
    logic [2:0]  irq;
    logic [31:0] cnt;
    logic        core_rstn_b, run_b, done_b;
    logic [2:0]  irq_b;
    logic [31:0] cnt_b;
`ifdef IRQ_STIM_MISS_CNT_EN
    logic [23:0] miss, miss_b;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    irq_stim_gen #(
        .NUM_IRQ(3), .RST_CYCLES(10), .RUN_CYCLES(10000), .CNT_W(32)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_period_i(cfg_period), .cfg_level_i(cfg_level),
        .irq_ack_i(ack), .core_rstn_o(core_rstn), .irq_o(irq),
        .run_o(run), .done_o(done),
`ifdef IRQ_STIM_MISS_CNT_EN
        .miss_cnt_o(miss),
`endif
        .cycle_cnt_o(cnt)
    );

    irq_stim_gen #(
        .NUM_IRQ(3), .RST_CYCLES(10), .RUN_CYCLES(0), .CNT_W(32)
    ) u_dut_inf (
        .clk_i(clk), .rstn_i(rstn), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_period_i(cfg_period), .cfg_level_i(cfg_level),
        .irq_ack_i(ack), .core_rstn_o(core_rstn_b), .irq_o(irq_b),
        .run_o(run_b), .done_o(done_b),
`ifdef IRQ_STIM_MISS_CNT_EN
        .miss_cnt_o(miss_b),
`endif
        .cycle_cnt_o(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        cfg_we = 1'b0;
        ack    = '0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [31:0] p,
                             input logic lvl);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_level  = lvl;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (run !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (run !== 1'b1) begin
            fails++;
            $display("FAIL %s_wait_run: run_o=%b, required 1", name, run);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        checks += 5;
        if (core_rstn !== 1'b0) begin
            fails++; $display("FAIL rst_core_rstn: got %b, required 0", core_rstn);
        end
        if (irq !== 3'b000) begin
            fails++; $display("FAIL rst_irq: got %b, required 000", irq);
        end
        if (run !== 1'b0) begin
            fails++; $display("FAIL rst_run: got %b, required 0", run);
        end
        if (done !== 1'b0) begin
            fails++; $display("FAIL rst_done: got %b, required 0", done);
        end
        if (cnt !== 32'd0) begin
            fails++; $display("FAIL rst_cnt: got %0d, required 0", cnt);
        end
    endtask

    task automatic test_hold_run_done();
        int bad = 0;
        int first = -1;
        rstn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (core_rstn !== 1'b0) begin
                fails++;
                $display("FAIL hold_edge%0d: core_rstn_o=%b, required 0", k, core_rstn);
            end
        end
        tick();
        checks += 3;
        if (core_rstn !== 1'b1 || run !== 1'b1) begin
            fails++;
            $display("FAIL run_entry: core_rstn_o=%b run_o=%b, required 1 1", core_rstn, run);
        end
        if (cnt !== 32'd0) begin
            fails++; $display("FAIL run_first_cnt: got %0d, required 0", cnt);
        end
        if (done !== 1'b0) begin
            fails++; $display("FAIL run_entry_done: got %b, required 0", done);
        end
        for (int k = 1; k <= 9999; k++) begin
            tick();
            if (cnt !== 32'(k) || run !== 1'b1 || irq !== 3'b000 || done !== 1'b0) begin
                if (bad == 0) first = k;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL run_window: %0d bad cycles (first %0d), required 0", bad, first);
        end
        tick();
        checks += 3;
        if (done !== 1'b1 || run !== 1'b0) begin
            fails++;
            $display("FAIL done_entry: done_o=%b run_o=%b, required 1 0", done, run);
        end
        if (cnt !== 32'd10000) begin
            fails++; $display("FAIL done_cnt: got %0d, required 10000", cnt);
        end
        if (core_rstn !== 1'b1 || irq !== 3'b000) begin
            fails++;
            $display("FAIL done_outs: core_rstn_o=%b irq_o=%b, required 1 000", core_rstn, irq);
        end
        checks++;
        if (run_b !== 1'b1 || done_b !== 1'b0 || cnt_b !== 32'd10000) begin
            fails++;
            $display("FAIL inf_run: run=%b done=%b cnt=%0d, required 1 0 10000",
                     run_b, done_b, cnt_b);
        end
        repeat (5) tick();
        checks += 2;
        if (done !== 1'b1 || cnt !== 32'd10000) begin
            fails++;
            $display("FAIL done_sticky: done=%b cnt=%0d, required 1 10000", done, cnt);
        end
        if (done_b !== 1'b0 || run_b !== 1'b1) begin
            fails++;
            $display("FAIL inf_never_done: done=%b run=%b, required 0 1", done_b, run_b);
        end
    endtask

    task automatic test_pulse();
        logic [2:0] exp;
        do_reset();
        write_cfg(2'd0, 32'd5, 1'b0);
        wait_run("pulse");
        for (int c = 0; c <= 30; c++) begin
            exp = (c > 0 && c % 5 == 0) ? 3'b001 : 3'b000;
            checks++;
            if (irq !== exp || cnt !== 32'(c)) begin
                fails++;
                $display("FAIL pulse_c%0d: irq_o=%b cnt=%0d, required %b %0d",
                         c, irq, cnt, exp, c);
            end
            tick();
        end
    endtask

    task automatic test_level();
        logic [27:0] ack_v;
        logic [27:0] exp_v;
        logic [2:0]  exp;
        ack_v = 28'h0682220;
        exp_v = 28'hF3F3330;
        do_reset();
        write_cfg(2'd2, 32'd4, 1'b1);
        wait_run("level");
        for (int c = 0; c < 28; c++) begin
            exp = {exp_v[c], 2'b00};
            checks++;
            if (irq !== exp) begin
                fails++;
                $display("FAIL level_c%0d: irq_o=%b, required %b", c, irq, exp);
            end
            ack = {ack_v[c], 2'b00};
            tick();
        end
        ack = '0;
    endtask

    task automatic test_period_one();
        logic [2:0] exp;
        do_reset();
        write_cfg(2'd1, 32'd1, 1'b0);
        wait_run("p1");
        for (int c = 0; c <= 10; c++) begin
            exp = (c == 0) ? 3'b000 : 3'b010;
            checks++;
            if (irq !== exp) begin
                fails++;
                $display("FAIL p1_c%0d: irq_o=%b, required %b", c, irq, exp);
            end
            if (c < 10) tick();
        end
        write_cfg(2'd1, 32'd0, 1'b0);
        checks++;
        if (irq !== 3'b000) begin
            fails++; $display("FAIL p1_disable: irq_o=%b, required 000", irq);
        end
        write_cfg(2'd3, 32'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (irq !== 3'b000) begin
                fails++;
                $display("FAIL bad_ch_c%0d: irq_o=%b, required 000", c, irq);
            end
            tick();
        end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        write_cfg(2'd0, 32'd5, 1'b0);
        wait_run("mid");
        repeat (300) tick();
        checks++;
        if (cnt !== 32'd300 || irq !== 3'b001) begin
            fails++;
            $display("FAIL mid_pre: cnt=%0d irq_o=%b, required 300 001", cnt, irq);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks += 2;
        if ({core_rstn, run, done, irq} !== 6'b0 || cnt !== 32'd0) begin
            fails++;
            $display("FAIL mid_rst: rstn=%b run=%b done=%b irq=%b cnt=%0d, required all 0",
                     core_rstn, run, done, irq, cnt);
        end
        if ({core_rstn_b, run_b, done_b, irq_b} !== 6'b0 || cnt_b !== 32'd0) begin
            fails++;
            $display("FAIL mid_rst_inf: rstn=%b run=%b cnt=%0d, required 0 0 0",
                     core_rstn_b, run_b, cnt_b);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (core_rstn !== 1'b0 || run !== 1'b0) begin
                fails++;
                $display("FAIL mid_hold%0d: core_rstn=%b run=%b, required 0 0", k, core_rstn, run);
            end
        end
        tick();
        checks++;
        if (run !== 1'b1 || core_rstn !== 1'b1 || cnt !== 32'd0) begin
            fails++;
            $display("FAIL mid_rerun: run=%b core_rstn=%b cnt=%0d, required 1 1 0",
                     run, core_rstn, cnt);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (irq !== 3'b000) begin
                fails++;
                $display("FAIL mid_cfg_clr_c%0d: irq_o=%b, required 000", c, irq);
            end
            tick();
        end
    endtask

`ifdef IRQ_STIM_MISS_CNT_EN
    task automatic test_miss();
        int bad = 0;
        int first = -1;
        int e;
        do_reset();
        write_cfg(2'd0, 32'd2, 1'b1);
        wait_run("miss");
        for (int c = 0; c <= 600; c++) begin
            e = (c < 4) ? 0 : ((c / 2 - 1 > 255) ? 255 : c / 2 - 1);
            if (miss[7:0] !== 8'(e) || miss[23:8] !== 16'd0) begin
                if (bad == 0) first = c;
                bad++;
            end
            if (c == 4 || c == 600) begin
                checks++;
                if (miss[7:0] !== 8'(e)) begin
                    fails++;
                    $display("FAIL miss_c%0d: got %0d, required %0d", c, miss[7:0], e);
                end
            end
            tick();
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL miss_seq: %0d bad cycles (first %0d), required 0", bad, first);
        end
        write_cfg(2'd0, 32'd2, 1'b1);
        checks++;
        if (miss[7:0] !== 8'd0) begin
            fails++; $display("FAIL miss_clear: got %0d, required 0", miss[7:0]);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn       = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_level  = 1'b0;
        ack        = '0;
        test_reset();
        test_hold_run_done();
        test_pulse();
        test_level();
        test_period_one();
        test_midrun_reset();
`ifdef IRQ_STIM_MISS_CNT_EN
        test_miss();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/irq_stim_gen.md
Name: irq_stim_gen

Overview:
- Synthesizable reset-sequencer and interrupt-stimulus generator for the neoRV32 accelerator wrapper bench and FPGA bring-up harness.
- Holds the core in reset for a fixed number of cycles, then runs it for a bounded (or unbounded) window.
- Drives NUM_IRQ programmable periodic interrupt lines: generalises the fixed mtime/msw/mext tie-offs to N channels with period, pulse/level mode and acknowledge.

Parameters:
- NUM_IRQ, 3, number of interrupt channels (ch0=mtime, ch1=msw, ch2=mext by convention); range 1..16.
- RST_CYCLES, 10, cycles core_rstn_o is held low after rstn_i releases; 0 allowed.
- RUN_CYCLES, 10000, length of the RUN window; 0 = run forever.
- CNT_W, 32, width of period registers and cycle counter.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  synchronous active-low reset.
- cfg_we_i  in  1  channel config write strobe.
- cfg_ch_i  in  CH_W  channel select; CH_W = max(1, clog2(NUM_IRQ)).
- cfg_period_i  in  CNT_W  interrupt period in cycles; 0 = channel disabled.
- cfg_level_i  in  1  1 = level mode (held until ack), 0 = pulse mode.
- irq_ack_i  in  NUM_IRQ  per-channel acknowledge, level mode only.
- core_rstn_o  out  1  reset to DUT core, active low.
- irq_o  out  NUM_IRQ  interrupt lines to DUT, registered.
- run_o  out  1  high while in RUN.
- done_o  out  1  high in DONE; sticky until rstn_i.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset (rstn_i=0 at a clk_i edge):
  - Outputs: core_rstn_o=0, irq_o=0, run_o=0, done_o=0, cycle_cnt_o=0.
  - All channel configs cleared (period=0, pulse mode); state HOLD.
  - Reset asserted mid-operation has the same effect, on the next edge.
- FSM HOLD -> RUN -> DONE:
  - HOLD: internal counter runs from 0. Go to RUN at the RST_CYCLES-th edge with rstn_i=1. RST_CYCLES=0: RUN at the first such edge.
  - Entering RUN: core_rstn_o=1 and run_o=1 in the same cycle.
  - RUN: cycle_cnt_o increments each cycle, starting at 0 in the first RUN cycle. If RUN_CYCLES!=0 and cycle_cnt_o==RUN_CYCLES-1, go to DONE next edge.
  - DONE: run_o=0, done_o=1, core_rstn_o stays 1, irq_o forced 0, cycle_cnt_o frozen at RUN_CYCLES. Leaves DONE only via rstn_i.
- Config:
  - cfg_we_i is accepted in any state; it writes period and mode for channel cfg_ch_i.
  - cfg_ch_i >= NUM_IRQ: write ignored.
  - A write reloads that channel's down-counter to period-1 on the next edge and clears its pending bit.
- Channel timing (RUN only, period P != 0):
  - Counter loads P-1 on entering RUN or on a config write, and decrements each cycle.
  - At 0 the channel "fires" and the counter reloads P-1.
  - irq_o[i] is registered: it is high the cycle after a fire. The first assertion is exactly P cycles after run_o rises; later ones every P cycles.
  - P=1: fires every cycle.
  - Pulse mode: irq_o[i] high for exactly one cycle per fire. With P=1 it is held continuously high.
  - Level mode: a fire sets pending; irq_o[i] follows pending. irq_ack_i[i]=1 clears pending on the next edge. Fire and ack in the same cycle: pending stays 1 (fire wins). Ack while not pending has no effect.
  - Period 0: channel disabled; irq_o[i]=0 and pending is cleared.
- irq_o is 0 in HOLD and DONE regardless of config.

Optional Feature:
- Macro: IRQ_STIM_MISS_CNT_EN.
- Defined:
  - Adds output miss_cnt_o (8*NUM_IRQ bits): one 8-bit saturating counter per channel, cleared on reset and on a config write to that channel.
  - Increments when a level-mode channel fires while already pending and no ack is given that cycle.
  - Saturates at 255.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Default params, no config -> core_rstn_o rises 10 cycles after rstn_i release; run_o high 10000 cycles; done_o=1; cycle_cnt_o=10000; irq_o always 0.
- ch0 P=5 pulse, written in HOLD -> irq_o[0] one-cycle pulses at RUN cycles 5, 10, 15, ...; ch1 and ch2 stay 0.
- ch2 P=4 level, ack 2 cycles after each assertion -> irq_o[2] high 2 cycles per period. Ack on a fire cycle -> irq_o[2] stays high.
- ch1 P=1 pulse -> irq_o[1] continuously high from second RUN cycle; rewrite P=0 mid-run -> irq_o[1]=0 next cycle.
- rstn_i=0 for one cycle mid-RUN at cycle 300 -> all outputs reset, configs cleared, HOLD restarts 10-cycle sequence; RUN_CYCLES=0 variant never asserts done_o.
- IRQ_STIM_MISS_CNT_EN, ch0 P=2 level, never ack -> miss_cnt_o[7:0] increments every 2 cycles, saturates at 255.
